// File: rtl/pulse_safety_monitor_pkg.sv
// Shared types for the pulse safety monitor: FSM encoding, status bit map, fault slots.
package pulse_safety_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } mon_state_e;

    // monitor_status bit positions as seen over I2C
    localparam int ST_SHORT   = 0;
    localparam int ST_LONG    = 1;
    localparam int ST_RATE    = 2;
    localparam int ST_ANY     = 3;
    localparam int ST_TRIG    = 4;
    localparam int ST_ARMED   = 5;
    localparam int ST_INPULSE = 6;
    localparam int ST_EN      = 7;

    // sticky fault slots, laid out to match status[2:0]
    localparam int F_SHORT    = 0;
    localparam int F_LONG     = 1;
    localparam int F_RATE     = 2;
    localparam int NUM_FAULTS = 3;

    typedef logic [NUM_FAULTS-1:0] fault_t;

endpackage

// File: rtl/pulse_safety_monitor_sync.sv
// Brings the asynchronous trigger into the clk domain and derives edge strobes.
module trig_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_in,
    output logic trig_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_d_q;

    // Synchronizer chain plus one extra delay for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            trig_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], trig_in};
            trig_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign trig_s = sync_q[SYNC_STAGES-1];
    assign rise   = trig_s & ~trig_d_q;
    assign fall   = ~trig_s & trig_d_q;

endmodule

// File: rtl/pulse_safety_monitor.sv
// Laser trigger pulse monitor: width/rate checks, sticky faults, laser-enable interlock.
module pulse_safety_monitor
    import pulse_safety_monitor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             enable,
    input  logic             clear_faults,
    input  logic [CNT_W-1:0] pulse_width_lower_limit,
    input  logic [CNT_W-1:0] pulse_width_upper_limit,
    input  logic [CNT_W-1:0] rate_lower_limit,
    output logic             laser_en_gate,
    output logic [7:0]       monitor_status,
    output logic [CNT_W-1:0] last_width
);

    logic trig_s, rise, fall;

    trig_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .trig_in(trig_in),
        .trig_s (trig_s),
        .rise   (rise),
        .fall   (fall)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] lo_sh_q, lo_sh_d;
    logic [CNT_W-1:0] up_sh_q, up_sh_d;
    logic [CNT_W-1:0] rate_sh_q, rate_sh_d;
    logic [CNT_W-1:0] last_w_q, last_w_d;
    fault_t           fault_q, fault_d, fault_set;
    logic             armed_q, armed_d;
    logic             gate_q, gate_d;
    logic             en_q;
    logic [7:0]       status;

    // Counters stick at all-ones so a stuck trigger never looks like a fresh short count
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state: FSM, counters, shadow limits, fault detection and gate
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        period_d  = period_q;
        lo_sh_d   = lo_sh_q;
        up_sh_d   = up_sh_q;
        rate_sh_d = rate_sh_q;
        last_w_d  = last_w_q;
        armed_d   = armed_q;
        fault_set = '0;

        if (!enable) begin
            // disabling drops everything but the sticky faults and last_width
            state_d  = S_IDLE;
            width_d  = '0;
            period_d = '0;
            armed_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_WAIT;   // an edge seen on this cycle is ignored
                S_WAIT, S_LOW: begin
                    if (rise) begin
                        // snapshot limits so mid-pulse writes only affect the next pulse
                        state_d   = S_HIGH;
                        lo_sh_d   = pulse_width_lower_limit;
                        up_sh_d   = pulse_width_upper_limit;
                        rate_sh_d = rate_lower_limit;
                        if (armed_q && (rate_sh_d != '0) && (period_q < rate_sh_d))
                            fault_set[F_RATE] = 1'b1;
                        armed_d  = 1'b1;
                        width_d  = CNT_W'(1);
                        period_d = CNT_W'(1);
                    end else begin
                        period_d = sat_inc(period_q);
                    end
                end
                S_HIGH: begin
                    period_d = sat_inc(period_q);
                    if (fall) begin
                        state_d  = S_LOW;
                        last_w_d = width_q;
                        if ((lo_sh_q != '0) && (width_q < lo_sh_q))
                            fault_set[F_SHORT] = 1'b1;
                    end else begin
                        width_d = sat_inc(width_q);
                        // flag as soon as the count passes the limit, not at the fall
                        if ((up_sh_q != '0) && (width_d > up_sh_q))
                            fault_set[F_LONG] = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // a new fault wins over a simultaneous clear
        fault_d = (clear_faults ? fault_t'(0) : fault_q) | fault_set;
        gate_d  = enable & ~(|fault_d);
    end

    // State and datapath registers; async reset forces the laser off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            period_q  <= '0;
            lo_sh_q   <= '0;
            up_sh_q   <= '0;
            rate_sh_q <= '0;
            last_w_q  <= '0;
            fault_q   <= '0;
            armed_q   <= 1'b0;
            gate_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            period_q  <= period_d;
            lo_sh_q   <= lo_sh_d;
            up_sh_q   <= up_sh_d;
            rate_sh_q <= rate_sh_d;
            last_w_q  <= last_w_d;
            fault_q   <= fault_d;
            armed_q   <= armed_d;
            gate_q    <= gate_d;
            en_q      <= enable;
        end
    end

    // Pack the status word for register-bank readback
    always_comb begin
        status             = '0;
        status[ST_SHORT]   = fault_q[F_SHORT];
        status[ST_LONG]    = fault_q[F_LONG];
        status[ST_RATE]    = fault_q[F_RATE];
        status[ST_ANY]     = |fault_q;
        status[ST_TRIG]    = trig_s;
        status[ST_ARMED]   = armed_q;
        status[ST_INPULSE] = (state_q == S_HIGH);
        status[ST_EN]      = en_q;
    end

    assign monitor_status = status;
    assign laser_en_gate  = gate_q;
    assign last_width     = last_w_q;

endmodule
